// File: rtl/mem_ctrl_pkg.sv
// Shared constants for mem_ctrl: request types, FSM encodings, byte count and load extension helpers.
// Pure definitions; no timing or flow-control behaviour lives here.
package mem_ctrl_pkg;

  localparam int   RegBus    = 32;
  localparam logic RstEnable = 1'b1;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_RLAST = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic [2:0] byte_count(input logic [3:0] op);
    logic [2:0] n;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: n = 3'd1;
      MEM_LH, MEM_LHU, MEM_SH: n = 3'd2;
      default:                 n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SB);
  endfunction

  function automatic logic [31:0] extend_load(input logic [3:0] op, input logic [31:0] raw);
    logic [31:0] r;
    case (op)
      MEM_LB:  r = {{24{raw[7]}}, raw[7:0]};
      MEM_LBU: r = {24'd0, raw[7:0]};
      MEM_LH:  r = {{16{raw[15]}}, raw[15:0]};
      MEM_LHU: r = {16'd0, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Combinational IF/MEM arbiter; MEM wins ties unless MEM_CTRL_ROUND_ROBIN_EN, where the
// requester not granted last wins. Zero latency; the caller only consults it while idle.
module mem_ctrl_arb (
  input  logic if_valid,
  input  logic mem_valid,
`ifdef MEM_CTRL_ROUND_ROBIN_EN
  input  logic last_mem,
`endif
  output logic grant,
  output logic sel_mem
);

  assign grant = if_valid | mem_valid;

`ifdef MEM_CTRL_ROUND_ROBIN_EN
  assign sel_mem = mem_valid & (~if_valid | ~last_mem);
`else
  assign sel_mem = mem_valid;
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port shared by IF and MEM; reads done at n+2, writes at n+1 cycles after grant.
// Requesters stall on mem_busy; optional MEM_CTRL_ROUND_ROBIN_EN selects round-robin tie-break.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [RegBus-1:0] if_addr,
  output logic              if_done,
  output logic [RegBus-1:0] if_data,
  input  logic              mem_req,
  input  logic [RegBus-1:0] mem_req_addr,
  input  logic [RegBus-1:0] mem_req_data,
  input  logic [3:0]        mem_req_type,
  output logic              mem_done,
  output logic [RegBus-1:0] mem_rdata,
  output logic              mem_busy,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [RegBus-1:0] ram_a,
  output logic              ram_wr
);

  logic [2:0]        state;
  logic [2:0]        cnt;
  logic [RegBus-1:0] req_addr;
  logic [RegBus-1:0] req_data;
  logic [3:0]        req_type;
  logic              req_mem;
  logic [RegBus-1:0] rbuf;
  logic [RegBus-1:0] assembled;
  logic [2:0]        nbytes;
  logic [1:0]        cap_idx;
  logic [1:0]        last_idx;
  logic              mem_valid;
  logic              grant;
  logic              sel_mem;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
  logic              last_mem;
`endif

  assign mem_valid = mem_req && (mem_req_type != MEM_NOP) && (mem_req_type <= MEM_SW);
  assign mem_busy  = (state != S_IDLE);
  assign nbytes    = byte_count(req_type);
  // cnt runs one ahead of the byte returning on ram_din (one-cycle RAM latency)
  assign cap_idx   = 2'(cnt - 3'd2);
  assign last_idx  = 2'(nbytes - 3'd1);

  always_comb begin
    assembled = rbuf;
    assembled[8*last_idx +: 8] = ram_din;
  end

  mem_ctrl_arb u_arb (
    .if_valid  (if_req),
    .mem_valid (mem_valid),
`ifdef MEM_CTRL_ROUND_ROBIN_EN
    .last_mem  (last_mem),
`endif
    .grant     (grant),
    .sel_mem   (sel_mem)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      req_addr  <= '0;
      req_data  <= '0;
      req_type  <= MEM_NOP;
      req_mem   <= 1'b0;
      rbuf      <= '0;
      if_done   <= 1'b0;
      if_data   <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      ram_a     <= '0;
      ram_dout  <= 8'd0;
      ram_wr    <= 1'b0;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
      last_mem  <= 1'b0;
`endif
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            req_mem  <= sel_mem;
            req_addr <= sel_mem ? mem_req_addr : if_addr;
            req_data <= mem_req_data;
            req_type <= sel_mem ? mem_req_type : MEM_LW;
            ram_a    <= sel_mem ? mem_req_addr : if_addr;
            cnt      <= 3'd1;
            rbuf     <= '0;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
            last_mem <= sel_mem;
`endif
            if (sel_mem && is_store(mem_req_type)) begin
              state    <= S_WRITE;
              ram_wr   <= 1'b1;
              ram_dout <= mem_req_data[7:0];
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (cnt != 3'd1) rbuf[8*cap_idx +: 8] <= ram_din;
          if (cnt == nbytes) begin
            state <= S_RLAST;
            ram_a <= '0;
          end else begin
            ram_a <= req_addr + RegBus'(cnt);
            cnt   <= cnt + 3'd1;
          end
        end
        S_RLAST: begin
          state <= S_DONE;
          if (req_mem) begin
            mem_rdata <= extend_load(req_type, assembled);
            mem_done  <= 1'b1;
          end else begin
            if_data <= assembled;
            if_done <= 1'b1;
          end
        end
        S_WRITE: begin
          if (cnt == nbytes) begin
            state    <= S_DONE;
            ram_wr   <= 1'b0;
            ram_a    <= '0;
            ram_dout <= 8'd0;
            mem_done <= 1'b1;
          end else begin
            ram_a    <= req_addr + RegBus'(cnt);
            ram_dout <= req_data[8*cnt[1:0] +: 8];
            cnt      <= cnt + 3'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_type;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  logic [7:0]  ram [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'd0;
  logic [7:0]  pre_dat = 8'd0;

  int checks = 0;
  int errors = 0;

  logic [31:0] a_log    [0:31];
  logic        wr_log   [0:31];
  logic [7:0]  dout_log [0:31];
  logic        busy_log [0:31];
  int          ifd_cyc, memd_cyc, ifd_cnt, memd_cnt;
  logic [31:0] ifd_dat, memd_dat;

  mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_done      (if_done),
    .if_data      (if_data),
    .mem_req      (mem_req),
    .mem_req_addr (mem_req_addr),
    .mem_req_data (mem_req_data),
    .mem_req_type (mem_req_type),
    .mem_done     (mem_done),
    .mem_rdata    (mem_rdata),
    .mem_busy     (mem_busy),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .ram_a        (ram_a),
    .ram_wr       (ram_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
    if (pre_we) ram[pre_addr] <= pre_dat;
    ram_din <= ram[ram_a[15:0]];
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_dat  = d;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Called at the start of cycle 0; logs cycles 1..ncyc sampled 1ns after each edge.
  task automatic run(input bit use_if, input logic [31:0] faddr,
                     input bit use_mem, input logic [3:0] typ, input logic [31:0] addr,
                     input logic [31:0] data, input bit rearm, input logic [31:0] addr2,
                     input int rst_cyc, input int ncyc);
    ifd_cyc = -1; memd_cyc = -1; ifd_cnt = 0; memd_cnt = 0;
    ifd_dat = '0; memd_dat = '0;
    if_req = use_if; if_addr = faddr;
    mem_req = use_mem; mem_req_type = typ; mem_req_addr = addr; mem_req_data = data;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      a_log[c] = ram_a; wr_log[c] = ram_wr; dout_log[c] = ram_dout; busy_log[c] = mem_busy;
      if (rst) begin
        rst = 1'b0; if_req = 1'b0; mem_req = 1'b0;
      end
      if (c == rst_cyc) rst = 1'b1;
      if (if_done) begin
        ifd_cnt++;
        if (ifd_cyc < 0) begin ifd_cyc = c; ifd_dat = if_data; end
        if_req = 1'b0;
      end
      if (mem_done) begin
        memd_cnt++;
        if (memd_cyc < 0) begin memd_cyc = c; memd_dat = mem_rdata; end
        if (rearm && memd_cnt == 1) mem_req_addr = addr2;
        else mem_req = 1'b0;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0;
    mem_req_addr = '0; mem_req_data = '0; mem_req_type = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({if_done, mem_done, mem_busy, ram_wr} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {if_done, mem_done, mem_busy, ram_wr});
    end
    checks++; if ({if_data, mem_rdata, ram_a, ram_dout} !== 104'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h expected zeros", if_data, mem_rdata, ram_a, ram_dout);
    end
    rst = 1'b0;
  endtask

  task automatic test_if_fetch;
    preload(16'h1000, 8'h78); preload(16'h1001, 8'h56);
    preload(16'h1002, 8'h34); preload(16'h1003, 8'h12);
    run(1'b1, 32'h0000_1000, 1'b0, 4'd0, '0, '0, 1'b0, '0, -1, 9);
    checks++; if (ifd_cyc !== 6) begin errors++; $display("FAIL if_done_cycle: got %0d expected 6", ifd_cyc); end
    checks++; if (ifd_dat !== 32'h1234_5678) begin errors++; $display("FAIL if_data: got %h expected 12345678", ifd_dat); end
    checks++; if (ifd_cnt !== 1 || memd_cnt !== 0) begin errors++; $display("FAIL if_pulses: got if %0d mem %0d expected 1 0", ifd_cnt, memd_cnt); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_log[k+1] !== 32'h1000 + k || wr_log[k+1] !== 1'b0) begin
        errors++; $display("FAIL if_addr_c%0d: got %h wr %b expected %h wr 0", k + 1, a_log[k+1], wr_log[k+1], 32'h1000 + k);
      end
    end
    checks++; if (a_log[5] !== 32'd0 || busy_log[6] !== 1'b1 || busy_log[7] !== 1'b0) begin
      errors++; $display("FAIL if_tail: got a5 %h busy6 %b busy7 %b expected 0 1 0", a_log[5], busy_log[6], busy_log[7]);
    end
    checks++; if (if_data !== 32'h1234_5678) begin errors++; $display("FAIL if_data_hold: got %h expected 12345678", if_data); end
  endtask

  task automatic test_load_ext;
    preload(16'h0020, 8'h80);
    preload(16'h0030, 8'h34); preload(16'h0031, 8'hF2);
    run(1'b0, '0, 1'b1, 4'd1, 32'h20, '0, 1'b0, '0, -1, 6);
    checks++; if (memd_cyc !== 3 || memd_dat !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb: got cycle %0d data %h expected 3 ffffff80", memd_cyc, memd_dat);
    end
    checks++; if (a_log[1] !== 32'h20 || a_log[2] !== 32'h0 || busy_log[4] !== 1'b0) begin
      errors++; $display("FAIL lb_seq: got a1 %h a2 %h busy4 %b expected 20 0 0", a_log[1], a_log[2], busy_log[4]);
    end
    run(1'b0, '0, 1'b1, 4'd4, 32'h20, '0, 1'b0, '0, -1, 6);
    checks++; if (memd_cyc !== 3 || memd_dat !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu: got cycle %0d data %h expected 3 00000080", memd_cyc, memd_dat);
    end
    run(1'b0, '0, 1'b1, 4'd2, 32'h30, '0, 1'b0, '0, -1, 7);
    checks++; if (memd_cyc !== 4 || memd_dat !== 32'hFFFF_F234) begin
      errors++; $display("FAIL lh: got cycle %0d data %h expected 4 fffff234", memd_cyc, memd_dat);
    end
    run(1'b0, '0, 1'b1, 4'd5, 32'h30, '0, 1'b0, '0, -1, 7);
    checks++; if (memd_cyc !== 4 || memd_dat !== 32'h0000_F234) begin
      errors++; $display("FAIL lhu: got cycle %0d data %h expected 4 0000f234", memd_cyc, memd_dat);
    end
  endtask

  task automatic test_store;
    logic [7:0] exp_b [0:3];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    run(1'b0, '0, 1'b1, 4'd8, 32'h100, 32'hDEAD_BEEF, 1'b0, '0, -1, 8);
    for (int k = 0; k < 4; k++) begin
      checks++; if (wr_log[k+1] !== 1'b1 || a_log[k+1] !== 32'h100 + k || dout_log[k+1] !== exp_b[k]) begin
        errors++; $display("FAIL sw_c%0d: got wr %b a %h d %h expected 1 %h %h",
                           k + 1, wr_log[k+1], a_log[k+1], dout_log[k+1], 32'h100 + k, exp_b[k]);
      end
    end
    checks++; if (memd_cyc !== 5 || wr_log[5] !== 1'b0 || busy_log[6] !== 1'b0) begin
      errors++; $display("FAIL sw_done: got cycle %0d wr5 %b busy6 %b expected 5 0 0", memd_cyc, wr_log[5], busy_log[6]);
    end
    run(1'b0, '0, 1'b1, 4'd3, 32'h100, '0, 1'b0, '0, -1, 8);
    checks++; if (memd_cyc !== 6 || memd_dat !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL lw_readback: got cycle %0d data %h expected 6 deadbeef", memd_cyc, memd_dat);
    end
    run(1'b0, '0, 1'b1, 4'd7, 32'h104, 32'hCAFE_1234, 1'b0, '0, -1, 6);
    checks++; if (memd_cyc !== 3 || wr_log[2] !== 1'b1 || dout_log[2] !== 8'h12 || wr_log[3] !== 1'b0) begin
      errors++; $display("FAIL sh: got cycle %0d wr2 %b d2 %h wr3 %b expected 3 1 12 0", memd_cyc, wr_log[2], dout_log[2], wr_log[3]);
    end
  endtask

  task automatic test_invalid_type;
    logic [3:0] bad [0:2];
    bad[0] = 4'd0; bad[1] = 4'd9; bad[2] = 4'd15;
    for (int i = 0; i < 3; i++) begin
      run(1'b0, '0, 1'b1, bad[i], 32'h20, '0, 1'b0, '0, -1, 4);
      checks++; if (busy_log[1] !== 1'b0 || busy_log[4] !== 1'b0 || memd_cnt !== 0) begin
        errors++; $display("FAIL invalid_type_%0d: got busy %b%b done %0d expected 0 0 0", bad[i], busy_log[1], busy_log[4], memd_cnt);
      end
    end
  endtask

  task automatic test_back_to_back;
    run(1'b1, 32'h0000_1000, 1'b1, 4'd1, 32'h20, '0, 1'b0, '0, -1, 12);
    checks++; if (a_log[1] !== 32'h20 || memd_cyc !== 3 || memd_dat !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL tie_mem_first: got a1 %h cycle %0d data %h expected 20 3 ffffff80", a_log[1], memd_cyc, memd_dat);
    end
    checks++; if (a_log[5] !== 32'h1000 || ifd_cyc !== 10 || ifd_dat !== 32'h1234_5678) begin
      errors++; $display("FAIL tie_if_next: got a5 %h cycle %0d data %h expected 1000 10 12345678", a_log[5], ifd_cyc, ifd_dat);
    end
  endtask

  task automatic test_second_tie;
    // MEM re-requests at its done pulse, so IF and MEM tie again in cycle 4
    run(1'b1, 32'h0000_1000, 1'b1, 4'd1, 32'h20, '0, 1'b1, 32'h30, -1, 16);
`ifdef MEM_CTRL_ROUND_ROBIN_EN
    checks++; if (a_log[5] !== 32'h1000 || ifd_cyc !== 10) begin
      errors++; $display("FAIL second_tie: got a5 %h if cycle %0d expected 1000 10", a_log[5], ifd_cyc);
    end
`else
    checks++; if (a_log[5] !== 32'h30 || ifd_cyc !== 14) begin
      errors++; $display("FAIL second_tie: got a5 %h if cycle %0d expected 30 14", a_log[5], ifd_cyc);
    end
`endif
    checks++; if (memd_cnt !== 2 || ifd_cnt !== 1) begin
      errors++; $display("FAIL second_tie_count: got mem %0d if %0d expected 2 1", memd_cnt, ifd_cnt);
    end
  endtask

  task automatic test_reset_mid;
    preload(16'hFFFF, 8'hCD); preload(16'h0000, 8'h7B);
    run(1'b0, '0, 1'b1, 4'd3, 32'h100, '0, 1'b0, '0, 2, 8);
    checks++; if (a_log[1] !== 32'h100 || a_log[2] !== 32'h101) begin
      errors++; $display("FAIL rst_pre: got a1 %h a2 %h expected 100 101", a_log[1], a_log[2]);
    end
    checks++; if (a_log[3] !== 32'h0 || wr_log[3] !== 1'b0 || busy_log[3] !== 1'b0 || memd_cnt !== 0) begin
      errors++; $display("FAIL rst_abort: got a3 %h wr %b busy %b done %0d expected 0 0 0 0", a_log[3], wr_log[3], busy_log[3], memd_cnt);
    end
    run(1'b0, '0, 1'b1, 4'd2, 32'hFFFF_FFFF, '0, 1'b0, '0, -1, 7);
    checks++; if (a_log[1] !== 32'hFFFF_FFFF || a_log[2] !== 32'h0) begin
      errors++; $display("FAIL wrap_addr: got a1 %h a2 %h expected ffffffff 0", a_log[1], a_log[2]);
    end
    checks++; if (memd_cyc !== 4 || memd_dat !== 32'h0000_7BCD) begin
      errors++; $display("FAIL wrap_lh: got cycle %0d data %h expected 4 00007bcd", memd_cyc, memd_dat);
    end
  endtask

  initial begin
    test_reset;
    test_if_fetch;
    test_load_ext;
    test_store;
    test_invalid_type;
    test_back_to_back;
    test_reset_mid;
    test_reset;
    test_second_tie;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
